// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared display constants and types for the 4-digit scan driver.
package seven_seg_scan_driver_pkg;

  localparam int NUM_DIGITS = 4;

  // Code that makes the downstream 7-segment decoder turn every segment off.
  localparam logic [3:0] BLANK_CODE = 4'd10;

  // Common-anode display: anodes are active-low, so all-ones is dark.
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } upd_state_e;

  // Active-low one-cold anode pattern for the given digit position.
  function automatic logic [NUM_DIGITS-1:0] digit_anode(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Signal bundle between game logic (master) and the scan driver (slave).
interface seven_seg_scan_driver_if;
  import seven_seg_scan_driver_pkg::*;

  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     en_in;
  logic [3:0]                bin;
  logic [NUM_DIGITS-1:0]     an;
  logic                      pending;
  logic                      frame_start;

  modport master (
    output load, digits_in, en_in,
    input  bin, an, pending, frame_start
  );

  modport slave (
    input  load, digits_in, en_in,
    output bin, an, pending, frame_start
  );

endinterface

// File: rtl/seven_seg_scan_driver_scan_slot_timer.sv
// Digit-slot timer: counts cycles within a slot and the digit index within
// a frame. Exposes next-state values so the top can register outputs that
// already reflect the post-edge position.
module seven_seg_scan_driver_scan_slot_timer #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] idx_d_o,
  output logic       dead_d_o,
  output logic       boundary_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          wrap;

  // Next slot position: wrap the counter and advance the digit together.
  always_comb begin
    wrap  = (cnt_q == CNT_LAST);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
  end

  // Slot position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_d_o    = idx_d;
  assign dead_d_o   = (cnt_d < CNT_DEAD);
  assign boundary_o = wrap && (idx_q == 2'd3);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Updates are held in a pending buffer and copied to the displayed shadow
// only at a frame boundary, so one frame never mixes old and new digits.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | shadow is current; nothing waiting
//   ST_PEND | pend_* holds an update to apply at the next boundary
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  seven_seg_scan_driver_if.slave  bus
);

  logic [1:0] idx_d;
  logic       dead_d;
  logic       boundary;

  upd_state_e               state_q, state_d;
  logic [4*NUM_DIGITS-1:0]  pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]    pend_en_q, pend_en_d;
  logic [4*NUM_DIGITS-1:0]  shadow_digits_q, shadow_digits_d;
  logic [NUM_DIGITS-1:0]    shadow_en_q, shadow_en_d;

  logic [NUM_DIGITS-1:0]    an_q, an_d;
  logic [3:0]               bin_q, bin_d;
  logic                     frame_start_q, frame_start_d;
  logic                     digit_on;
  logic [3:0]               nibble;

  seven_seg_scan_driver_scan_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .idx_d_o    (idx_d),
    .dead_d_o   (dead_d),
    .boundary_o (boundary)
  );

  // Update sequencing: buffer loads mid-frame, commit at the boundary. A load
  // landing on the boundary itself bypasses the buffer and wins.
  always_comb begin
    state_d         = state_q;
    pend_digits_d   = pend_digits_q;
    pend_en_d       = pend_en_q;
    shadow_digits_d = shadow_digits_q;
    shadow_en_d     = shadow_en_q;
    if (boundary) begin
      state_d = ST_IDLE;
      if (bus.load) begin
        shadow_digits_d = bus.digits_in;
        shadow_en_d     = bus.en_in;
      end else if (state_q == ST_PEND) begin
        shadow_digits_d = pend_digits_q;
        shadow_en_d     = pend_en_q;
      end
    end else if (bus.load) begin
      pend_digits_d = bus.digits_in;
      pend_en_d     = bus.en_in;
      state_d       = ST_PEND;
    end
  end

  // Output mux driven from next-state values so registered outputs line up
  // with the slot position they belong to.
  always_comb begin
    digit_on      = shadow_en_d[idx_d];
    nibble        = shadow_digits_d[{idx_d, 2'b00} +: 4];
    bin_d         = digit_on ? nibble : BLANK_CODE;
    an_d          = (dead_d || !digit_on) ? AN_OFF : digit_anode(idx_d);
    frame_start_d = boundary;
  end

  // State, buffer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pend_digits_q   <= '0;
      pend_en_q       <= '0;
      shadow_digits_q <= '0;
      shadow_en_q     <= '0;
      an_q            <= AN_OFF;
      bin_q           <= BLANK_CODE;
      frame_start_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_digits_q   <= pend_digits_d;
      pend_en_q       <= pend_en_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_en_q     <= shadow_en_d;
      an_q            <= an_d;
      bin_q           <= bin_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.bin         = bin_q;
  assign bus.pending     = (state_q == ST_PEND);
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Testbench for seven_seg_scan_driver: directed scenarios plus random loads
// and resets, checked every cycle against a cycle-position reference model.
module tb_seven_seg_scan_driver;

  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_scan_driver_if bus();

  seven_seg_scan_driver #(
    .REFRESH_DIV (DIV),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]  an;
    logic [3:0]  bin;
    logic        pending;
    logic        fs;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  // Reference model: position k counts edges since reset; shadow/pending
  // hold what the display should be showing.
  int          k = 0;
  logic [15:0] m_sh = '0;
  logic [3:0]  m_en = '0;
  logic [15:0] m_pd = '0;
  logic [3:0]  m_pe = '0;
  bit          m_pending = 1'b0;

  function automatic exp_t model_out(input int pos, input int cyc);
    exp_t e;
    int slot, c;
    slot = (pos / DIV) % 4;
    c    = pos % DIV;
    if (m_en[slot]) begin
      e.bin = 4'((m_sh >> (4 * slot)) & 16'hF);
      e.an  = (c < DEAD) ? 4'hF : 4'(15 - (1 << slot));
    end else begin
      e.bin = 4'd10;
      e.an  = 4'hF;
    end
    e.pending = m_pending;
    e.fs      = (pos > 0) && (pos % FRAME == 0);
    e.cyc     = cyc;
    return e;
  endfunction

  task automatic step(input bit r, input bit ld, input logic [15:0] d, input logic [3:0] e);
    @(negedge clk);
    rst           = r;
    bus.load      = ld;
    bus.digits_in = d;
    bus.en_in     = e;
    if (r) begin
      k = 0; m_sh = '0; m_en = '0; m_pd = '0; m_pe = '0; m_pending = 1'b0;
    end else begin
      if (k % FRAME == FRAME - 1) begin
        if (ld) begin
          m_sh = d; m_en = e;
        end else if (m_pending) begin
          m_sh = m_pd; m_en = m_pe;
        end
        m_pending = 1'b0;
      end else if (ld) begin
        m_pd = d; m_pe = e; m_pending = 1'b1;
      end
      k++;
    end
    ncyc++;
    exp_q.push_back(model_out(k, ncyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic idle_until(input int pos);
    for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a new output set; compare it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("an",          e.cyc, bus.an,                 e.an);
        chk("bin",         e.cyc, bus.bin,                e.bin);
        chk("pending",     e.cyc, {3'b000, bus.pending},  {3'b000, e.pending});
        chk("frame_start", e.cyc, {3'b000, bus.frame_start}, {3'b000, e.fs});
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.load = 1'b0;
    bus.digits_in = '0;
    bus.en_in = '0;

    // reset, then idle with blank display
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(40);

    // mid-frame load of 3210, all enabled
    idle_until(10);
    step(1'b0, 1'b1, 16'h3210, 4'hF);
    idle(70);

    // partial enables
    idle_until(5);
    step(1'b0, 1'b1, 16'hFE98, 4'b0101);
    idle(70);

    // two loads in one frame: last wins
    idle_until(3);
    step(1'b0, 1'b1, 16'h1111, 4'hF);
    idle(4);
    step(1'b0, 1'b1, 16'h2222, 4'hF);
    idle(70);

    // load exactly on the boundary overrides the pending value
    idle_until(12);
    step(1'b0, 1'b1, 16'h1111, 4'hF);
    idle_until(FRAME - 1);
    step(1'b0, 1'b1, 16'h4444, 4'hF);
    idle(40);

    // reset during digit2 slot with an update pending
    idle_until(10);
    step(1'b0, 1'b1, 16'h5678, 4'hF);
    idle_until(18);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(40);

    // random loads, boundary-aligned loads and occasional resets
    for (int i = 0; i < 600; i++) begin
      bit r, ld;
      r  = ($urandom_range(0, 149) == 0);
      ld = ($urandom_range(0, 7) == 0);
      step(r, ld, 16'($urandom), 4'($urandom_range(0, 15)));
    end
    idle(10);

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
